// File: rtl/block_sync_aligner_if.sv
// Gearbox buffer feed into the sync-header aligner, and its alignment status back.
// BLOCK_SYNC_STATS_EN adds the two statistics counters to the bus.
interface block_sync_aligner_if #(
  parameter int FRAME_W = 66,
  parameter int BUF_W   = 194
);
  localparam int POS_W = $clog2(FRAME_W);

  logic [BUF_W-1:0] gbox_buffer;
  logic             buffer_dv;
  logic             is_synced;
  logic [POS_W-1:0] offset_pos;
  logic [1:0]       align_state;
  logic             lock_lost;
`ifdef BLOCK_SYNC_STATS_EN
  logic [15:0]      stat_bad_hdr;
  logic [15:0]      stat_relock;
`endif

  modport master (
    output gbox_buffer,
    output buffer_dv,
    input  is_synced,
    input  offset_pos,
    input  align_state,
    input  lock_lost
`ifdef BLOCK_SYNC_STATS_EN
    , input stat_bad_hdr
    , input stat_relock
`endif
  );

  modport slave (
    input  gbox_buffer,
    input  buffer_dv,
    output is_synced,
    output offset_pos,
    output align_state,
    output lock_lost
`ifdef BLOCK_SYNC_STATS_EN
    , output stat_bad_hdr
    , output stat_relock
`endif
  );
endinterface

// File: rtl/block_sync_aligner.sv
// Sync-header aligner: N_SEEKERS parallel seekers feed a HUNT/VERIFY/LOCKED FSM; outputs are registered on the deciding dv edge.
// No backpressure: cycles with buffer_dv=0 change nothing. BLOCK_SYNC_STATS_EN adds stat_bad_hdr/stat_relock counters.
module block_sync_aligner #(
  parameter int FRAME_W    = 66,
  parameter int BUF_W      = 194,
  parameter int N_SEEKERS  = 11,
  parameter int CAND_CNT   = 4,
  parameter int LOCK_CNT   = 32,
  parameter int WIN_LEN    = 64,
  parameter int UNLOCK_CNT = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  block_sync_aligner_if.slave bus
);
  localparam int POS_W  = $clog2(FRAME_W);
  localparam int CCNT_W = $clog2(CAND_CNT + 1);
  localparam int VCNT_W = $clog2(LOCK_CNT + 1);
  localparam int WCNT_W = $clog2(WIN_LEN + 1);
  localparam int BCNT_W = $clog2(UNLOCK_CNT + 1);

  localparam logic [CCNT_W-1:0] CAND_LAST   = CCNT_W'(CAND_CNT - 1);
  localparam logic [CCNT_W-1:0] CAND_MAX    = CCNT_W'(CAND_CNT);
  localparam logic [VCNT_W-1:0] LOCK_LAST   = VCNT_W'(LOCK_CNT - 1);
  localparam logic [WCNT_W-1:0] WIN_LAST    = WCNT_W'(WIN_LEN - 1);
  localparam logic [BCNT_W-1:0] UNLOCK_LAST = BCNT_W'(UNLOCK_CNT - 1);
  localparam logic [POS_W:0]    POS_STEP    = (POS_W + 1)'(N_SEEKERS);
  localparam logic [POS_W:0]    POS_LIMIT   = (POS_W + 1)'(FRAME_W);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  state_t             state_q;
  logic [POS_W-1:0]   offset_q;
  logic               synced_q;
  logic               lock_lost_q;
  logic               sticky_vld_q;
  logic [VCNT_W-1:0]  ver_cnt_q;
  logic [WCNT_W-1:0]  win_cnt_q;
  logic [BCNT_W-1:0]  bad_cnt_q;

  logic [FRAME_W-1:0]   hdr_vld;
  logic [POS_W-1:0]     sk_pos [N_SEEKERS];
  logic [N_SEEKERS-1:0] sk_hit;

  logic             hdr_at_off;
  logic             ver_fail;
  logic             bad_evt;
  logic             unlock_evt;
  logic             hunt_entry;
  logic             hunt_adv;
  logic             any_hit;
  logic             sticky_hit;
  logic [POS_W-1:0] win_pos;

  // A sync header is valid when its two bits differ (01 or 10).
  for (genvar p = 0; p < FRAME_W; p++) begin : g_hdr
    assign hdr_vld[p] = bus.gbox_buffer[p+1] ^ bus.gbox_buffer[p];
  end

  assign hdr_at_off = hdr_vld[offset_q];
  assign ver_fail   = bus.buffer_dv && (state_q == ST_VERIFY) && !hdr_at_off;
  assign bad_evt    = bus.buffer_dv && (state_q == ST_LOCKED) && !hdr_at_off;
  assign unlock_evt = bad_evt && (bad_cnt_q == UNLOCK_LAST);
  assign hunt_entry = ver_fail || unlock_evt;
  assign hunt_adv   = bus.buffer_dv && (state_q == ST_HUNT);

  for (genvar k = 0; k < N_SEEKERS; k++) begin : g_seek
    localparam logic [POS_W-1:0] START = POS_W'(k);

    logic [POS_W-1:0]  pos_q;
    logic [CCNT_W-1:0] cnt_q;
    logic [POS_W:0]    pos_sum;
    logic              hdr_ok;

    assign pos_sum   = {1'b0, pos_q} + POS_STEP;
    assign hdr_ok    = hdr_vld[pos_q];
    assign sk_pos[k] = pos_q;
    assign sk_hit[k] = hdr_ok && (cnt_q == CAND_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pos_q <= START;
        cnt_q <= '0;
      end else if (hunt_entry) begin
        pos_q <= START;
        cnt_q <= '0;
      end else if (hunt_adv) begin
        if (hdr_ok) begin
          if (cnt_q != CAND_MAX) cnt_q <= cnt_q + 1'b1;
        end else begin
          cnt_q <= '0;
          pos_q <= (pos_sum >= POS_LIMIT) ? START : pos_sum[POS_W-1:0];
        end
      end
    end
  end

  // Lowest hitting index wins, unless a hitter sits on the previous offset.
  always_comb begin
    any_hit    = 1'b0;
    sticky_hit = 1'b0;
    win_pos    = '0;
    for (int k = N_SEEKERS - 1; k >= 0; k--) begin
      if (sk_hit[k]) begin
        any_hit = 1'b1;
        win_pos = sk_pos[k];
      end
    end
    for (int k = 0; k < N_SEEKERS; k++) begin
      if (sk_hit[k] && sticky_vld_q && (sk_pos[k] == offset_q)) sticky_hit = 1'b1;
    end
    if (sticky_hit) win_pos = offset_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_HUNT;
      offset_q     <= '0;
      synced_q     <= 1'b0;
      lock_lost_q  <= 1'b0;
      sticky_vld_q <= 1'b0;
      ver_cnt_q    <= '0;
      win_cnt_q    <= '0;
      bad_cnt_q    <= '0;
    end else begin
      lock_lost_q <= 1'b0;
      if (bus.buffer_dv) begin
        case (state_q)
          ST_HUNT: begin
            if (any_hit) begin
              state_q      <= ST_VERIFY;
              offset_q     <= win_pos;
              sticky_vld_q <= 1'b1;
              ver_cnt_q    <= '0;
            end
          end
          ST_VERIFY: begin
            // offset_q is kept on failure so the next hunt can prefer it.
            if (!hdr_at_off) begin
              state_q <= ST_HUNT;
            end else if (ver_cnt_q == LOCK_LAST) begin
              state_q   <= ST_LOCKED;
              synced_q  <= 1'b1;
              win_cnt_q <= '0;
              bad_cnt_q <= '0;
            end else begin
              ver_cnt_q <= ver_cnt_q + 1'b1;
            end
          end
          ST_LOCKED: begin
            // Threshold on the window's last frame beats the window clear.
            if (unlock_evt) begin
              state_q     <= ST_HUNT;
              synced_q    <= 1'b0;
              lock_lost_q <= 1'b1;
            end else if (win_cnt_q == WIN_LAST) begin
              win_cnt_q <= '0;
              bad_cnt_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + 1'b1;
              if (!hdr_at_off) bad_cnt_q <= bad_cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end
  end

  assign bus.is_synced   = synced_q;
  assign bus.offset_pos  = offset_q;
  assign bus.align_state = state_q;
  assign bus.lock_lost   = lock_lost_q;

`ifdef BLOCK_SYNC_STATS_EN
  logic [15:0] stat_bad_q;
  logic [15:0] stat_relock_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_bad_q    <= '0;
      stat_relock_q <= '0;
    end else begin
      if (bad_evt && (stat_bad_q != 16'hFFFF)) stat_bad_q <= stat_bad_q + 16'd1;
      if (unlock_evt && (stat_relock_q != 16'hFFFF)) stat_relock_q <= stat_relock_q + 16'd1;
    end
  end

  assign bus.stat_bad_hdr = stat_bad_q;
  assign bus.stat_relock  = stat_relock_q;
`endif
endmodule

// File: tb/tb_block_sync_aligner.sv
// Bench for block_sync_aligner: table of frame runs with expected status, plus reset and stats sequences.
module tb_block_sync_aligner;
  localparam int FRAME_W = 66;
  localparam int BUF_W   = 194;

  localparam int P_BAD  = 0;  // all ones: every header invalid
  localparam int P_A    = 1;  // valid headers at 25 and 26
  localparam int P_B    = 2;  // valid headers at 22, 23, 25 and 26
  localparam int P_IDLE = 3;  // buffer_dv low

  localparam logic [1:0] S_H = 2'b00;
  localparam logic [1:0] S_V = 2'b01;
  localparam logic [1:0] S_L = 2'b10;

  typedef struct {
    string      name;
    int         pat;
    int         n;
    bit         gap;
    logic [1:0] st;
    int         off;
    bit         sync;
    bit         lost;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t exp_q[$];
  vec_t vecs[24];

  always #5 clk_i = ~clk_i;

  block_sync_aligner_if #(.FRAME_W(FRAME_W), .BUF_W(BUF_W)) bus ();

  block_sync_aligner dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int pat);
    logic [BUF_W-1:0] b;
    @(negedge clk_i);
    b = '1;
    if (pat == P_A) b[26:25] = 2'b01;
    if (pat == P_B) b[26:23] = 4'b0110;
    bus.gbox_buffer = b;
    bus.buffer_dv   = (pat != P_IDLE);
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic [1:0] st, input int off,
                               input bit sync, input bit lost);
    check({name, ".state"}, int'(bus.align_state), int'(st));
    check({name, ".offset"}, int'(bus.offset_pos), off);
    check({name, ".synced"}, int'(bus.is_synced), int'(sync));
    check({name, ".lost"}, int'(bus.lock_lost), int'(lost));
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    exp_q.push_back(v);
    for (int i = 0; i < v.n; i++) begin
      if (v.gap) drive(P_IDLE);
      drive(v.pat);
    end
    e = exp_q.pop_front();
    check_outputs(e.name, e.st, e.off, e.sync, e.lost);
  endtask

  initial begin
    vecs[0]  = '{"hunt_5",       P_A,    5,  1'b0, S_H, 0,  1'b0, 1'b0};
    vecs[1]  = '{"verify_entry", P_A,    1,  1'b0, S_V, 25, 1'b0, 1'b0};
    vecs[2]  = '{"verify_9",     P_A,    9,  1'b0, S_V, 25, 1'b0, 1'b0};
    vecs[3]  = '{"verify_fail",  P_BAD,  1,  1'b0, S_H, 25, 1'b0, 1'b0};
    vecs[4]  = '{"rehunt",       P_A,    6,  1'b0, S_V, 25, 1'b0, 1'b0};
    vecs[5]  = '{"verify_31",    P_A,    31, 1'b0, S_V, 25, 1'b0, 1'b0};
    vecs[6]  = '{"lock_32",      P_A,    1,  1'b0, S_L, 25, 1'b1, 1'b0};
    vecs[7]  = '{"w1_bad15",     P_BAD,  15, 1'b0, S_L, 25, 1'b1, 1'b0};
    vecs[8]  = '{"w1_good",      P_A,    49, 1'b0, S_L, 25, 1'b1, 1'b0};
    vecs[9]  = '{"w2_bad15",     P_BAD,  15, 1'b0, S_L, 25, 1'b1, 1'b0};
    vecs[10] = '{"w2_good",      P_A,    49, 1'b0, S_L, 25, 1'b1, 1'b0};
    vecs[11] = '{"w3_bad15",     P_BAD,  15, 1'b0, S_L, 25, 1'b1, 1'b0};
    vecs[12] = '{"w3_good",      P_A,    49, 1'b0, S_L, 25, 1'b1, 1'b0};
    vecs[13] = '{"unl_15",       P_BAD,  15, 1'b0, S_L, 25, 1'b1, 1'b0};
    vecs[14] = '{"unl_16",       P_BAD,  1,  1'b0, S_H, 25, 1'b0, 1'b1};
    vecs[15] = '{"lost_clear",   P_IDLE, 1,  1'b0, S_H, 25, 1'b0, 1'b0};
    vecs[16] = '{"sticky_b",     P_B,    6,  1'b0, S_V, 25, 1'b0, 1'b0};
    vecs[17] = '{"sticky_lock",  P_B,    32, 1'b0, S_L, 25, 1'b1, 1'b0};
    vecs[18] = '{"unlock2",      P_BAD,  16, 1'b0, S_H, 25, 1'b0, 1'b1};
    vecs[19] = '{"gap_37",       P_A,    37, 1'b1, S_V, 25, 1'b0, 1'b0};
    vecs[20] = '{"gap_38",       P_A,    1,  1'b1, S_L, 25, 1'b1, 1'b0};
    vecs[21] = '{"edge_good48",  P_A,    48, 1'b0, S_L, 25, 1'b1, 1'b0};
    vecs[22] = '{"edge_bad15",   P_BAD,  15, 1'b0, S_L, 25, 1'b1, 1'b0};
    vecs[23] = '{"edge_unlock",  P_BAD,  1,  1'b0, S_H, 25, 1'b0, 1'b1};

    rst_i           = 1'b1;
    bus.buffer_dv   = 1'b0;
    bus.gbox_buffer = '1;
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs("reset", S_H, 0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 24; i++) apply(vecs[i]);

`ifdef BLOCK_SYNC_STATS_EN
    check("stat_relock", int'(bus.stat_relock), 3);
    check("stat_bad_hdr", int'(bus.stat_bad_hdr), 93);
`endif

    // Back into VERIFY, then reset asynchronously between clock edges.
    apply('{"reverify", P_A, 10, 1'b0, S_V, 25, 1'b0, 1'b0});
    #2;
    rst_i = 1'b1;
    #1;
    check_outputs("async_rst", S_H, 0, 1'b0, 1'b0);
`ifdef BLOCK_SYNC_STATS_EN
    check("rst_stat_relock", int'(bus.stat_relock), 0);
    check("rst_stat_bad_hdr", int'(bus.stat_bad_hdr), 0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;

    // Reset forgets the previous offset, so lowest index (offset 22) wins.
    apply('{"nosticky_b", P_B, 6, 1'b0, S_V, 22, 1'b0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/block_sync_aligner.md
Name: block_sync_aligner

Overview:
- Parametrised successor to the hierarchical sync-header seeker in the Aurora 64b/66b receive path. It sits after the gearbox buffer and before the descrambler.
- N_SEEKERS parallel seekers hunt for the 2-bit sync-header offset within a FRAME_W-bit frame. A HUNT/VERIFY/LOCKED state machine confirms the winning offset.
- Once LOCKED, it monitors header errors in a sliding frame window and drops lock on excess errors.
- Adds features the previous seeker lacked: lock confirmation, loss-of-lock detection, sticky re-acquisition and configurable frame width.

Parameters:
- FRAME_W, 66, frame length in bits; candidate offsets are 0..FRAME_W-1.
- BUF_W, 194, gearbox buffer width; must be at least FRAME_W+1.
- N_SEEKERS, 11, number of parallel seekers; legal range 1..FRAME_W.
- CAND_CNT, 4, consecutive valid headers that make a seeker's offset a candidate.
- LOCK_CNT, 32, consecutive valid headers in VERIFY needed to declare lock.
- WIN_LEN, 64, frames per error-monitoring window in LOCKED.
- UNLOCK_CNT, 16, bad headers within one window that force loss of lock.
- POS_W, $clog2(FRAME_W), derived localparam; offset width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- gbox_buffer  in  BUF_W  gearbox buffer contents.
- buffer_dv  in  1  buffer valid; all state advances only on edges where buffer_dv=1.
- is_synced  out  1  high while in LOCKED.
- offset_pos  out  POS_W  current candidate or locked offset.
- align_state  out  2  state encoding: HUNT=00, VERIFY=01, LOCKED=10.
- lock_lost  out  1  one-cycle pulse on the LOCKED->HUNT transition.

Behaviour:
- Reset and clocking:
  - Clock is clk_i only; rst_i is asynchronous and active-high and clears every register.
  - Reset values: is_synced=0, offset_pos=0, align_state=HUNT, lock_lost=0. All seeker positions, seeker counters and window counters also reset.
- Header test:
  - The header at offset p is gbox_buffer[p+1:p].
  - 01 or 10 is valid; 00 or 11 is invalid.
- Seekers (seeker k, 0 <= k < N_SEEKERS):
  - Scans positions k, k+N_SEEKERS, ... while the position is below FRAME_W, then wraps back to k.
  - On each dv edge in HUNT: valid header increments the seeker's counter (saturating at CAND_CNT); invalid header clears the counter and advances the seeker to its next position.
  - Seekers are frozen in VERIFY and LOCKED.
  - On every entry to HUNT, each seeker restarts at position k with its counter cleared.
- HUNT:
  - A seeker hits when its counter is CAND_CNT-1 and the current header is valid.
  - On the dv edge with one or more hits, the FSM goes to VERIFY and offset_pos latches the winner's position, registered on that same edge.
  - Arbitration among hits: the seeker whose position equals the previous offset_pos wins (sticky, valid after the first lock attempt). Otherwise the lowest seeker index wins.
- VERIFY:
  - Checks the header at offset_pos on every dv edge, starting with the dv edge after entry.
  - LOCK_CNT consecutive valid headers move the FSM to LOCKED; is_synced=1 is registered on the edge of the LOCK_CNT-th valid header.
  - Any invalid header returns the FSM to HUNT. offset_pos is held, which keeps stickiness.
- LOCKED:
  - A window counter counts dv frames 0..WIN_LEN-1; a bad counter counts invalid headers.
  - When the bad counter reaches UNLOCK_CNT, the FSM goes to HUNT, lock_lost pulses for 1 cycle and is_synced drops on the same edge.
  - At window wrap, both counters clear.
  - If the threshold is reached on the last frame of a window, unlock takes priority over the window clear.
- buffer_dv=0: no state change; lock_lost returns to 0.
- Reset mid-operation: immediately returns to reset values, regardless of state.
- Minimum lock latency from reset: (misses by the winning seeker) + CAND_CNT + LOCK_CNT dv edges.

Optional Feature:
- Macro: BLOCK_SYNC_STATS_EN.
- When defined, adds two outputs:
  - stat_bad_hdr  out 16  saturating count of invalid headers seen in LOCKED.
  - stat_relock  out 16  saturating count of lock_lost events.
  - Both reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Common stimulus: defaults; buffer all ones except gbox_buffer[26:25]=2'b01 on every dv.
- Clean lock: dv every cycle -> align_state goes to VERIFY after 6 dv edges with offset_pos=25; is_synced=1 after 38 dv edges.
- Tie arbitration: same stimulus -> seeker 4 at offset 26 also hits on the same edge; offset_pos must be 25, the lowest index.
- VERIFY failure: invalidate the header on the 10th VERIFY frame -> state returns to HUNT and offset_pos stays 25. Restore the header -> locks at 25 via stickiness.
- Loss of lock: once LOCKED, inject 16 invalid headers within one 64-frame window -> lock_lost pulses once and is_synced=0 on the 16th. Inject 15 per window over 3 windows -> lock is held.
- dv gaps and reset: toggle buffer_dv 1/0 -> lock takes 38 dv edges, not 38 cycles. Assert rst_i asynchronously mid-VERIFY -> all outputs are 0 before the next clock edge.
- Stats, only with BLOCK_SYNC_STATS_EN: two unlock events -> stat_relock=2 and stat_bad_hdr=32.
